// File: rtl/sum_window_pkg.sv
// Shared types and constants for the window-sum monitor slice.
// Included by sum_window_debounce and sum_window_monitor.
package sum_window_pkg;

  localparam int SUM_W   = 10;
  localparam int AVG_W   = 8;
  localparam int CNT_MAX = 255;
  localparam int DBC_W   = 4;

  typedef enum logic [1:0] {
    ST_NORMAL     = 2'd0,
    ST_PEND_ALARM = 2'd1,
    ST_ALARM      = 2'd2,
    ST_PEND_CLEAR = 2'd3
  } win_state_e;

  // Rounded quarter of a window sum, clipped to the average width.
  function automatic logic [AVG_W-1:0] avg_round_sat(input logic [SUM_W-1:0] sum);
    logic [SUM_W:0]   rnd;
    logic [SUM_W-2:0] quarter;
    rnd     = {1'b0, sum} + (SUM_W+1)'(2);
    quarter = rnd[SUM_W:2];
    return quarter[SUM_W-2] ? {AVG_W{1'b1}} : quarter[AVG_W-1:0];
  endfunction

endpackage

// File: rtl/sum_window_debounce.sv
// Alarm FSM with debounce counter and hysteresis.
// state_o exposes the FSM state for status readout and checkers.
module sum_window_debounce
  import sum_window_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_i,
  input  logic       q_high_i,
  input  logic       q_low_i,
  output win_state_e state_o,
  output logic       alarm_o,
  output logic       alarm_rise_o,
  output logic       set_o
);

  localparam logic [DBC_W-1:0] DEB_L = DBC_W'(DEBOUNCE);

  win_state_e       state_q;
  logic [DBC_W-1:0] cnt_q;
  logic [DBC_W-1:0] cnt_inc;
  logic             alarm_q;
  logic             alarm_rise_q;

  assign cnt_inc = cnt_q + DBC_W'(1);

  // set_o marks the sample that enters ALARM from the non-alarm side;
  // the event counter in the top consumes it on the same edge.
  always_comb begin
    set_o = 1'b0;
    if (sample_i && q_high_i) begin
      case (state_q)
        ST_NORMAL:     set_o = (DEBOUNCE == 1);
        ST_PEND_ALARM: set_o = (cnt_inc == DEB_L);
        default:       set_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_NORMAL;
      cnt_q        <= '0;
      alarm_q      <= 1'b0;
      alarm_rise_q <= 1'b0;
    end else begin
      alarm_rise_q <= 1'b0;
      if (sample_i) begin
        case (state_q)
          ST_NORMAL: begin
            if (q_high_i) begin
              if (set_o) begin
                state_q      <= ST_ALARM;
                cnt_q        <= '0;
                alarm_q      <= 1'b1;
                alarm_rise_q <= 1'b1;
              end else begin
                state_q <= ST_PEND_ALARM;
                cnt_q   <= DBC_W'(1);
              end
            end
          end
          ST_PEND_ALARM: begin
            if (q_high_i) begin
              if (set_o) begin
                state_q      <= ST_ALARM;
                cnt_q        <= '0;
                alarm_q      <= 1'b1;
                alarm_rise_q <= 1'b1;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= ST_NORMAL;
              cnt_q   <= '0;
            end
          end
          ST_ALARM: begin
            if (q_low_i) begin
              if (DEBOUNCE == 1) begin
                state_q <= ST_NORMAL;
                cnt_q   <= '0;
                alarm_q <= 1'b0;
              end else begin
                state_q <= ST_PEND_CLEAR;
                cnt_q   <= DBC_W'(1);
              end
            end
          end
          ST_PEND_CLEAR: begin
            // Falling back to ALARM here is not a new alarm event.
            if (q_low_i) begin
              if (cnt_inc == DEB_L) begin
                state_q <= ST_NORMAL;
                cnt_q   <= '0;
                alarm_q <= 1'b0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= ST_ALARM;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q <= ST_NORMAL;
            cnt_q   <= '0;
            alarm_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state_o      = state_q;
  assign alarm_o      = alarm_q;
  assign alarm_rise_o = alarm_rise_q;

endmodule

// File: rtl/sum_window_monitor.sv
// Window-sum monitor: rounded average, debounced alarm, event count.
// Min/max tracking is built only when SUM_WINDOW_MINMAX_EN is defined.
module sum_window_monitor
  import sum_window_pkg::*;
#(
  parameter int HIGH_TH  = 600,
  parameter int LOW_TH   = 400,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             sum_valid,
  output logic [AVG_W-1:0] avg,
  output logic             alarm,
  output logic             alarm_rise,
  output logic [1:0]       state,
  output logic [7:0]       event_cnt,
  output logic [SUM_W-1:0] min_sum,
  output logic [SUM_W-1:0] max_sum
);

  logic             q_high;
  logic             q_low;
  logic             set_evt;
  win_state_e       fsm_state;
  logic [AVG_W-1:0] avg_q;
  logic [7:0]       event_cnt_q;

  assign q_high = (sum_in >= SUM_W'(HIGH_TH));
  assign q_low  = (sum_in <  SUM_W'(LOW_TH));

  sum_window_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .sample_i    (sum_valid),
    .q_high_i    (q_high),
    .q_low_i     (q_low),
    .state_o     (fsm_state),
    .alarm_o     (alarm),
    .alarm_rise_o(alarm_rise),
    .set_o       (set_evt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avg_q       <= '0;
      event_cnt_q <= '0;
    end else if (sum_valid) begin
      avg_q <= avg_round_sat(sum_in);
      if (set_evt && (event_cnt_q != 8'(CNT_MAX))) begin
        event_cnt_q <= event_cnt_q + 8'd1;
      end
    end
  end

`ifdef SUM_WINDOW_MINMAX_EN
  logic [SUM_W-1:0] min_q;
  logic [SUM_W-1:0] max_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_q <= {SUM_W{1'b1}};
      max_q <= '0;
    end else if (sum_valid) begin
      if (sum_in < min_q) min_q <= sum_in;
      if (sum_in > max_q) max_q <= sum_in;
    end
  end

  assign min_sum = min_q;
  assign max_sum = max_q;
`else
  assign min_sum = '0;
  assign max_sum = '0;
`endif

  assign avg       = avg_q;
  assign state     = fsm_state;
  assign event_cnt = event_cnt_q;

endmodule

// File: doc/sum_window_monitor.md
# sum_window_monitor

Downstream consumer of the 4-sample sliding-window sum stage. Takes the 10-bit window sum each clock and produces three results. First, a rounded, saturated 8-bit average. Second, a debounced high/low threshold alarm with hysteresis, driven by a 4-state FSM. Third, a saturating count of alarm events. Optionally it also tracks the min/max sum since reset. It feeds the status/readout logic.

## Interface
- HIGH_TH, 600: alarm-set threshold on sum (10-bit); must satisfy LOW_TH < HIGH_TH
- LOW_TH, 400: alarm-clear threshold on sum (10-bit)
- DEBOUNCE, 3: consecutive qualifying samples required to change alarm state; legal range 1..15
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high; clock clk
- sum_in  input  10  window sum from upstream stage
- sum_valid  input  1  sample qualifier; tie to 1 when upstream updates every cycle
- avg  output  8  registered rounded average of last valid sum
- alarm  output  1  high in ALARM and PEND_CLEAR
- alarm_rise  output  1  one-cycle pulse on entry to ALARM
- state  output  2  FSM state: 0 NORMAL, 1 PEND_ALARM, 2 ALARM, 3 PEND_CLEAR
- event_cnt  output  8  number of alarm_rise events, saturating at 255
- min_sum, max_sum  output  10  extremes of valid sums since reset (see Configuration)

## Operation
- Only cycles with sum_valid=1 are samples. With sum_valid=0, the FSM, debounce counter, avg, event_cnt and min/max hold, and alarm_rise is 0.
- avg = min((sum_in + 2) >> 2, 255). The addition uses 11 bits.
- A sample qualifies-high when sum_in >= HIGH_TH, and qualifies-low when sum_in < LOW_TH.
- NORMAL:
  - qualifies-high with DEBOUNCE=1 → ALARM.
  - qualifies-high otherwise → PEND_ALARM, cnt=1.
- PEND_ALARM:
  - qualifies-high, cnt+1==DEBOUNCE → ALARM, cnt=0.
  - qualifies-high otherwise → cnt+1.
  - non-qualifying → NORMAL, cnt=0.
- ALARM:
  - qualifies-low → PEND_CLEAR (or NORMAL if DEBOUNCE=1), cnt=1.
- PEND_CLEAR:
  - qualifies-low, cnt+1==DEBOUNCE → NORMAL, cnt=0.
  - qualifies-low otherwise → cnt+1.
  - non-qualifying → ALARM, cnt=0.
- Hysteresis band: while in ALARM, sums in [LOW_TH, HIGH_TH) keep the alarm.
- alarm_rise fires on every transition into ALARM from NORMAL or PEND_ALARM. It does not fire on PEND_CLEAR→ALARM. event_cnt increments with alarm_rise and stays at 255 once reached.

## Timing
- All outputs are registered and update on posedge clk.
- Latency: avg reflects the sample taken at the previous edge (1 cycle).
- alarm asserts on the edge that samples the DEBOUNCE-th consecutive qualifying-high sum. The same holds for deassert on the DEBOUNCE-th qualifying-low sum.
- alarm_rise is high for exactly one cycle, concurrent with the first cycle of alarm=1.
- Reset, asserted at any time including mid-PEND, is immediate, independent of clk, and sets:
  - avg=0, alarm=0, alarm_rise=0, state=NORMAL, cnt=0, event_cnt=0
  - min_sum=1023, max_sum=0
- First valid sample after reset release is processed normally.

## Configuration
- SUM_WINDOW_MINMAX_EN defined:
  - min_sum and max_sum are registered running extremes of valid sums.
  - Both update on the same edge as avg.
- Not defined:
  - The tracking registers are not built.
  - min_sum and max_sum ports remain and are tied to 0, so the bench port list is stable.

## Structure
- Shared package sum_window_pkg holds:
  - state enum typedef (NORMAL, PEND_ALARM, ALARM, PEND_CLEAR)
  - SUM_W=10, AVG_W=8, CNT_MAX=255
- One sub-module is natural: sum_window_debounce, containing the FSM plus debounce counter. Its inputs are sample, qualifies-high and qualifies-low; its outputs are state, alarm and alarm_rise.
- The top holds the avg, event_cnt and min/max datapath.

## Test plan
All scenarios use defaults (600/400/3), with sum_valid=1 unless noted.
- Reset: assert reset → avg=0, alarm=0, state=0, event_cnt=0, max_sum=0, min_sum=1023 (macro on).
- Set: sums 100,700,700,700:
  - avg reads 25 then 175.
  - state goes 0,1,1,2; alarm=1 after 3rd 700.
  - alarm_rise exactly one cycle; event_cnt=1.
- Aborted set: 700,700,599 → state 1,1,0; alarm never asserts; event_cnt unchanged.
- Hysteresis clear: from ALARM, 399,399,450,399,399,399:
  - state 3,3,2,3,3,0; alarm drops only after the final 399.
  - no alarm_rise at the 450 re-entry.
- Rounding/saturation: 1023→avg 255; 1021→255; 6→2; 5→1; 1→0.
- Hold and mid-reset:
  - sum_valid=0 for 4 cycles while in PEND_ALARM → state/cnt held.
  - Then reset mid-PEND → state 0 immediately. After release, 700×3 → alarm and event_cnt=1.
